// File: rtl/photodetector_integrator.sv
// WDM photodetector with windowed integration and ADC quantisation.
// Optical power is summed per sample, then averaged and coded to AdcBits over valid/ready.

package photodetector_integrator_pkg;

  typedef struct {
    real power;
  } wave_t;

  typedef struct {
    wave_t wave_bundle[8];
  } waves8_t;

endpackage

module photodetector_integrator
  import photodetector_integrator_pkg::*;
#(
  parameter type         waves_t          = waves8_t,
  parameter int unsigned NumChannels      = 8,
  parameter real         Responsivity     = 1.0,
  parameter real         DarkCurrent      = 0.0,
  parameter real         FullScaleCurrent = 1.0,
  parameter int unsigned AdcBits          = 10,
  parameter int unsigned WinW             = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  waves_t                 i_phot_waves,
  input  logic [NumChannels-1:0] i_chan_mask,
  input  logic                   i_start,
  input  logic [WinW-1:0]        i_win_len,
  output real                    o_real_current,
  output logic                   o_busy,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [AdcBits-1:0]     o_code,
  output logic                   o_sat,
  output real                    o_real_avg
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StInteg = 2'd1;
  localparam logic [1:0] StConv  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  localparam real MaxCode = real'((64'd1 << AdcBits) - 64'd1);

  logic [1:0]             r_state;
  logic [1:0]             w_state_d;
  logic [NumChannels-1:0] r_mask;
  logic [WinW-1:0]        r_len;
  logic [WinW-1:0]        r_cnt;
  real                    r_acc;
  real                    r_real_current;
  real                    r_real_avg;
  logic [AdcBits-1:0]     r_code;
  logic                   r_sat;

  real                    w_sum_mask;
  real                    w_sum_all;
  real                    w_i_inst;
  real                    w_i_all;
  real                    w_avg;
  real                    w_x;
  logic [AdcBits-1:0]     w_code;
  logic                   w_sat;
  logic                   w_start_ok;
  logic                   w_last;
  logic [WinW-1:0]        w_len_eff;

  // Photocurrent: masked sum drives integration, unmasked sum feeds the monitor output.
  always_comb begin
    w_sum_mask = 0.0;
    w_sum_all  = 0.0;
    for (int i = 0; i < NumChannels; i++) begin
      w_sum_all = w_sum_all + i_phot_waves.wave_bundle[i].power;
      if (r_mask[i]) begin
        w_sum_mask = w_sum_mask + i_phot_waves.wave_bundle[i].power;
      end
    end
    w_i_inst = Responsivity * w_sum_mask + DarkCurrent;
    w_i_all  = Responsivity * w_sum_all + DarkCurrent;
  end

  // Clamp in the real domain so the real-to-int conversion never sees an out-of-range value.
  always_comb begin
    w_avg  = r_acc / real'(r_len);
    w_x    = (w_avg / FullScaleCurrent) * MaxCode;
    w_code = '0;
    w_sat  = 1'b0;
    if (w_x <= 0.0) begin
      w_code = '0;
    end else if (w_x > MaxCode) begin
      w_code = '1;
      w_sat  = 1'b1;
    end else begin
      w_code = AdcBits'($rtoi(w_x + 0.5));
    end
  end

  assign w_start_ok = i_start && ((r_state == StIdle) || ((r_state == StHold) && i_ready));
  assign w_last     = (r_cnt == r_len - WinW'(1));
  assign w_len_eff  = (i_win_len == '0) ? WinW'(1) : i_win_len;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_d = StInteg;
      StInteg: if (w_last) w_state_d = StConv;
      StConv:  w_state_d = StHold;
      StHold: begin
        if (i_ready) w_state_d = i_start ? StInteg : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_mask         <= '0;
      r_len          <= WinW'(1);
      r_cnt          <= '0;
      r_acc          <= 0.0;
      r_real_current <= 0.0;
      r_real_avg     <= 0.0;
      r_code         <= '0;
      r_sat          <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_real_current <= w_i_all;
      if (w_start_ok) begin
        r_mask <= i_chan_mask;
        r_len  <= w_len_eff;
        r_cnt  <= '0;
        r_acc  <= 0.0;
      end else if (r_state == StInteg) begin
        r_acc <= r_acc + w_i_inst;
        r_cnt <= r_cnt + WinW'(1);
      end
      if (r_state == StConv) begin
        r_real_avg <= w_avg;
        r_code     <= w_code;
        r_sat      <= w_sat;
      end
    end
  end

  assign o_real_current = r_real_current;
  assign o_real_avg     = r_real_avg;
  assign o_code         = r_code;
  assign o_sat          = r_sat;
  assign o_busy         = (r_state == StInteg) || (r_state == StConv);
  assign o_valid        = (r_state == StHold);

endmodule

// File: tb/tb_photodetector_integrator.sv
// Directed bench for photodetector_integrator: two instances, default and with dark current.

module tb_photodetector_integrator;
  import photodetector_integrator_pkg::*;

  logic        clk;
  logic        rst;
  waves8_t     waves;
  logic [7:0]  mask;
  logic        start;
  logic [7:0]  win_len;
  logic        ready;

  real         cur0, avg0, cur1, avg1;
  logic        busy0, valid0, sat0, busy1, valid1, sat1;
  logic [9:0]  code0, code1;

  int checks = 0;
  int errors = 0;

  photodetector_integrator dut0 (
    .i_clk(clk), .i_rst(rst), .i_phot_waves(waves), .i_chan_mask(mask),
    .i_start(start), .i_win_len(win_len), .o_real_current(cur0), .o_busy(busy0),
    .o_valid(valid0), .i_ready(ready), .o_code(code0), .o_sat(sat0), .o_real_avg(avg0)
  );

  photodetector_integrator #(.DarkCurrent(0.05)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_phot_waves(waves), .i_chan_mask(mask),
    .i_start(start), .i_win_len(win_len), .o_real_current(cur1), .o_busy(busy1),
    .o_valid(valid1), .i_ready(ready), .o_code(code1), .o_sat(sat1), .o_real_avg(avg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit rdiff(input real a, input real b);
    return (a - b > 1.0e-6) || (b - a > 1.0e-6);
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input real p);
    for (int i = 0; i < 8; i++) waves.wave_bundle[i].power = p;
  endtask

  // Start edge, then L+1 more edges lands in HOLD.
  task automatic launch(input logic [7:0] len, input logic [7:0] m);
    win_len = len;
    mask    = m;
    start   = 1'b1;
    step(1);
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0; mask = 8'hFF; win_len = 8'd4;
    set_all(0.1);
    step(3);
    checks++; if (rdiff(cur0, 0.0)) begin errors++; $display("FAIL rst_cur got %f want 0.0", cur0); end
    checks++; if (rdiff(avg0, 0.0)) begin errors++; $display("FAIL rst_avg got %f want 0.0", avg0); end
    checks++; if ({busy0, valid0, sat0} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b want 000", {busy0, valid0, sat0}); end
    checks++; if (code0 !== 10'd0) begin errors++; $display("FAIL rst_code got %0d want 0", code0); end
    rst = 1'b0;
    step(3);
    checks++; if ({busy0, valid0} !== 2'b00) begin
      errors++; $display("FAIL idle_flags got %b want 00", {busy0, valid0}); end
    checks++; if (rdiff(cur0, 0.8)) begin errors++; $display("FAIL idle_cur got %f want 0.8", cur0); end
  endtask

  task automatic test_nominal();
    set_all(0.1);
    launch(8'd4, 8'hFF);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL nom_busy got %b want 1", busy0); end
    step(4);
    checks++; if ({busy0, valid0} !== 2'b10) begin
      errors++; $display("FAIL nom_conv got %b want 10", {busy0, valid0}); end
    step(1);
    checks++; if ({busy0, valid0} !== 2'b01) begin
      errors++; $display("FAIL nom_valid got %b want 01", {busy0, valid0}); end
    checks++; if (rdiff(avg0, 0.8)) begin errors++; $display("FAIL nom_avg got %f want 0.8", avg0); end
    checks++; if ({sat0, code0} !== {1'b0, 10'd818}) begin
      errors++; $display("FAIL nom_code got %0d sat %b want 818 sat 0", code0, sat0); end
    checks++; if (rdiff(cur0, 0.8)) begin errors++; $display("FAIL nom_cur got %f want 0.8", cur0); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL nom_drop got %b want 0", valid0); end
  endtask

  task automatic test_mask_dark();
    set_all(0.1);
    launch(8'd4, 8'h0F);
    mask = 8'hFF;  // ignored until next start
    step(5);
    checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL md_valid got %b want 1", valid1); end
    checks++; if (rdiff(avg1, 0.45)) begin errors++; $display("FAIL md_avg got %f want 0.45", avg1); end
    checks++; if (code1 !== 10'd460) begin errors++; $display("FAIL md_code got %0d want 460", code1); end
    checks++; if (rdiff(cur1, 0.85)) begin errors++; $display("FAIL md_cur got %f want 0.85", cur1); end
    checks++; if (code0 !== 10'd409) begin errors++; $display("FAIL md_code0 got %0d want 409", code0); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  task automatic test_saturation();
    set_all(0.2);
    launch(8'd4, 8'hFF);
    step(5);
    checks++; if ({sat0, code0} !== {1'b1, 10'd1023}) begin
      errors++; $display("FAIL sat_code got %0d sat %b want 1023 sat 1", code0, sat0); end
    checks++; if (rdiff(avg0, 1.6)) begin errors++; $display("FAIL sat_avg got %f want 1.6", avg0); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    step(2);
    checks++; if ({valid0, sat0, code0} !== {1'b0, 1'b1, 10'd1023}) begin
      errors++; $display("FAIL sat_hold got v%b s%b %0d want v0 s1 1023", valid0, sat0, code0); end
  endtask

  task automatic test_ramp();
    set_all(0.0);
    launch(8'd4, 8'hFF);
    for (int k = 1; k <= 4; k++) begin
      waves.wave_bundle[0].power = 0.1 * k;
      step(1);
    end
    set_all(0.0);
    step(1);
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL ramp_valid got %b want 1", valid0); end
    checks++; if (rdiff(avg0, 0.25)) begin errors++; $display("FAIL ramp_avg got %f want 0.25", avg0); end
    checks++; if (code0 !== 10'd256) begin errors++; $display("FAIL ramp_code got %0d want 256", code0); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  task automatic test_win_zero();
    set_all(0.05);
    launch(8'd0, 8'hFF);
    step(1);
    checks++; if ({busy0, valid0} !== 2'b10) begin
      errors++; $display("FAIL w0_conv got %b want 10", {busy0, valid0}); end
    step(1);
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL w0_valid got %b want 1", valid0); end
    checks++; if (code0 !== 10'd409) begin errors++; $display("FAIL w0_code got %0d want 409", code0); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_all(0.1);
    launch(8'd4, 8'hFF);
    step(1);
    start = 1'b1;  // mid-INTEG pulse must be ignored
    step(1);
    start = 1'b0;
    step(3);
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", valid0); end
    checks++; if (code0 !== 10'd818) begin errors++; $display("FAIL bp_code got %0d want 818", code0); end
    set_all(0.3);
    for (int k = 0; k < 10; k++) begin
      step(1);
      checks++;
      if ({valid0, sat0, code0} !== {1'b1, 1'b0, 10'd818} || rdiff(avg0, 0.8)) begin
        errors++;
        $display("FAIL bp_stable[%0d] got v%b s%b %0d %f want v1 s0 818 0.8",
                 k, valid0, sat0, code0, avg0);
      end
    end
    set_all(0.05);
    ready = 1'b1;
    start = 1'b1;
    step(1);
    ready = 1'b0;
    start = 1'b0;
    checks++; if ({busy0, valid0} !== 2'b10) begin
      errors++; $display("FAIL b2b_restart got %b want 10", {busy0, valid0}); end
    step(4);
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL b2b_early got %b want 0", valid0); end
    step(1);
    checks++; if ({valid0, code0} !== {1'b1, 10'd409}) begin
      errors++; $display("FAIL b2b_result got v%b %0d want v1 409", valid0, code0); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_all(0.3);
    launch(8'd8, 8'hFF);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if ({busy0, valid0, sat0, code0} !== 13'd0) begin
      errors++; $display("FAIL rm_state got b%b v%b s%b %0d want all 0", busy0, valid0, sat0, code0);
    end
    checks++; if (rdiff(avg0, 0.0)) begin errors++; $display("FAIL rm_avg got %f want 0.0", avg0); end
    set_all(0.05);
    launch(8'd8, 8'hFF);
    step(9);
    checks++; if ({valid0, code0} !== {1'b1, 10'd409}) begin
      errors++; $display("FAIL rm_fresh got v%b %0d want v1 409", valid0, code0); end
    checks++; if (rdiff(avg0, 0.4)) begin errors++; $display("FAIL rm_avg2 got %f want 0.4", avg0); end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mask_dark();
    test_saturation();
    test_ramp();
    test_win_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
